// File: rtl/modexp_pkg.sv
// Shared encodings for the Montgomery exponentiation sequencer: datapath
// op codes, accumulator sources and controller states.
package modexp_pkg;

  localparam logic [1:0] OP_SQR       = 2'd0;
  localparam logic [1:0] OP_MUL       = 2'd1;
  localparam logic [1:0] OP_TO_MONT   = 2'd2;
  localparam logic [1:0] OP_FROM_MONT = 2'd3;

  localparam logic ACC_SRC_BASE = 1'b0;
  localparam logic ACC_SRC_ONE  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    LOAD,
    SQ,
    MUL,
    OUT,
    DONE
  } state_t;

endpackage

// File: rtl/modexp_ctrl_exp_scanner.sv
// Exponent shift register plus remaining-bit counter; exposes the current
// MSB-first test bit and end-of-exponent flags to the sequencer.
module exp_scanner
  import modexp_pkg::*;
#(
  parameter int EXP_W = 3072,
  parameter int CNT_W = $clog2(EXP_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [EXP_W-1:0] exp_in,
  output logic             test_bit,
  output logic             cnt_zero,
  output logic             cnt_one
);

  logic [EXP_W-1:0] e;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e   <= '0;
      cnt <= '0;
    end else if (load) begin
      e   <= exp_in;
      cnt <= CNT_W'(EXP_W);
    end else if (shift) begin
      e   <= {e[EXP_W-2:0], 1'b0};
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign test_bit = e[EXP_W-1];
  assign cnt_zero = (cnt == '0);
  // cnt_one lets the FSM know a shift this cycle exhausts the exponent.
  assign cnt_one  = (cnt == CNT_W'(1));

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for Montgomery modexp; issues
// single-cycle ops to a shared modmul datapath and waits for its completion.
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int EXP_W = 3072,
  parameter int CNT_W = $clog2(EXP_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [EXP_W-1:0] exp,
  output logic             busy,
  output logic             done,
  output logic             mm_en,
  output logic [1:0]       mm_op,
  input  logic             mm_done,
  output logic             acc_ld,
  output logic             acc_src
);

  state_t state;
  logic   conv_ok;
  logic   test_bit, cnt_zero, cnt_one;
  logic   load, shift, mm_ok;

  // A completion is only genuine after the op pulse has been issued.
  assign mm_ok = mm_done && !mm_en;
  assign load  = (state == IDLE) && start;

  always_comb begin
    shift = 1'b0;
    unique case (state)
      CONV:    shift = !test_bit && !cnt_zero;
      LOAD:    shift = !cnt_zero;
      SQ:      shift = mm_ok && !test_bit;
      MUL:     shift = mm_ok;
      default: shift = 1'b0;
    endcase
  end

  exp_scanner #(
    .EXP_W (EXP_W),
    .CNT_W (CNT_W)
  ) u_scanner (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .exp_in   (exp),
    .test_bit (test_bit),
    .cnt_zero (cnt_zero),
    .cnt_one  (cnt_one)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      conv_ok <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      mm_en   <= 1'b0;
      mm_op   <= OP_SQR;
      acc_ld  <= 1'b0;
      acc_src <= ACC_SRC_BASE;
    end else begin
      mm_en  <= 1'b0;
      acc_ld <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= CONV;
            busy    <= 1'b1;
            conv_ok <= 1'b0;
            mm_en   <= 1'b1;
            mm_op   <= OP_TO_MONT;
          end
        end
        CONV: begin
          // TO_MONT completion may land before the leading-zero scan ends.
          if (mm_ok) conv_ok <= 1'b1;
          if (conv_ok && (test_bit || cnt_zero)) begin
            state   <= LOAD;
            acc_ld  <= 1'b1;
            acc_src <= cnt_zero ? ACC_SRC_ONE : ACC_SRC_BASE;
          end
        end
        LOAD: begin
          mm_en <= 1'b1;
          if (cnt_zero || cnt_one) begin
            state <= OUT;
            mm_op <= OP_FROM_MONT;
          end else begin
            state <= SQ;
            mm_op <= OP_SQR;
          end
        end
        SQ: begin
          if (mm_ok) begin
            mm_en <= 1'b1;
            if (test_bit) begin
              state <= MUL;
              mm_op <= OP_MUL;
            end else if (cnt_one) begin
              state <= OUT;
              mm_op <= OP_FROM_MONT;
            end else begin
              state <= SQ;
              mm_op <= OP_SQR;
            end
          end
        end
        MUL: begin
          if (mm_ok) begin
            mm_en <= 1'b1;
            if (cnt_one) begin
              state <= OUT;
              mm_op <= OP_FROM_MONT;
            end else begin
              state <= SQ;
              mm_op <= OP_SQR;
            end
          end
        end
        OUT: begin
          if (mm_ok) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Directed bench for modexp_ctrl (EXP_W=8) with a latency-programmable stub
// datapath and an event scoreboard built from the exponent bits.
module tb_modexp_ctrl;
  import modexp_pkg::*;

  localparam int EXP_W   = 8;
  localparam int CNT_W   = $clog2(EXP_W + 1);
  localparam int EV_LD0  = 4;
  localparam int EV_LD1  = 5;
  localparam int EV_DONE = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [EXP_W-1:0] exp_val = '0;
  logic             busy, done, mm_en, acc_ld, acc_src, mm_done;
  logic [1:0]       mm_op;
  logic             stub_done = 1'b0;
  logic             inj_done = 1'b0;
  logic             prev_en = 1'b0;
  int               pending = 0;
  int               lat = 3;
  int               total = 0;
  int               bad = 0;
  int               exp_q[$];

  assign mm_done = stub_done | inj_done;

  always #5 clk = ~clk;

  modexp_ctrl #(
    .EXP_W (EXP_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .exp     (exp_val),
    .busy    (busy),
    .done    (done),
    .mm_en   (mm_en),
    .mm_op   (mm_op),
    .mm_done (mm_done),
    .acc_ld  (acc_ld),
    .acc_src (acc_src)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic observe(input int ev);
    if (exp_q.size() == 0) check("extra_event", ev, 32'hFF);
    else check("op_seq", ev, exp_q.pop_front());
  endtask

  // Stub datapath: mm_done is high exactly lat cycles after the mm_en cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= 0;
      stub_done <= 1'b0;
    end else begin
      stub_done <= 1'b0;
      if (pending != 0) begin
        pending <= pending - 1;
        if (pending == 1) stub_done <= 1'b1;
      end
      if (mm_en) begin
        if (lat <= 1) stub_done <= 1'b1;
        else pending <= lat - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_en <= 1'b0;
    end else begin
      if (mm_en) begin
        check("en_width", prev_en, 0);
        observe(int'(mm_op));
      end
      if (acc_ld) observe(acc_src ? EV_LD1 : EV_LD0);
      if (done) begin
        check("busy_at_done", busy, 1);
        observe(EV_DONE);
      end
      prev_en <= mm_en;
    end
  end

  task automatic push_model(input logic [EXP_W-1:0] e);
    int m = -1;
    exp_q.push_back(int'(OP_TO_MONT));
    for (int i = EXP_W - 1; i >= 0; i--) begin
      if (e[i] && m < 0) m = i;
    end
    if (m < 0) begin
      exp_q.push_back(EV_LD1);
    end else begin
      exp_q.push_back(EV_LD0);
      for (int i = m - 1; i >= 0; i--) begin
        exp_q.push_back(int'(OP_SQR));
        if (e[i]) exp_q.push_back(int'(OP_MUL));
      end
    end
    exp_q.push_back(int'(OP_FROM_MONT));
    exp_q.push_back(EV_DONE);
  endtask

  task automatic launch(input logic [EXP_W-1:0] e, input int l);
    lat = l;
    push_model(e);
    @(negedge clk);
    start   = 1'b1;
    exp_val = e;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_latency", {busy, mm_en, mm_op}, {1'b1, 1'b1, OP_TO_MONT});
  endtask

  task automatic finish_run();
    int seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check("done_timeout", seen, 1);
    @(negedge clk);
    check("busy_after_done", {busy, done}, 0);
    check("queue_empty", exp_q.size(), 0);
  endtask

  // kind 0: wait for acc_ld; kind 1: wait for a SQR issue.
  task automatic wait_ev(input int kind, output int seen);
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if ((kind == 0 && acc_ld) || (kind == 1 && mm_en && mm_op == OP_SQR)) begin
        seen = 1;
        break;
      end
    end
  endtask

  initial begin
    int seen;
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", {busy, done, mm_en, acc_ld, mm_op, acc_src}, 0);
    rst = 1'b0;

    launch(8'h0B, 3); finish_run();
    launch(8'h00, 3); finish_run();
    launch(8'h80, 3); finish_run();
    launch(8'h01, 3); finish_run();
    launch(8'hFF, 1); finish_run();

    // Stray completion in IDLE, then in LOAD, plus a start while busy.
    @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    launch(8'h0B, 3);
    wait_ev(0, seen);
    check("load_seen", seen, 1);
    inj_done = 1'b1;
    @(posedge clk);
    #1;
    inj_done = 1'b0;
    wait_ev(1, seen);
    check("sq_seen", seen, 1);
    start   = 1'b1;
    exp_val = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_run();

    // Asynchronous abort while waiting in SQ.
    launch(8'h0B, 3);
    wait_ev(1, seen);
    check("sq_before_reset", seen, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {busy, mm_en, done, acc_ld}, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    launch(8'h03, 3); finish_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
